// File: rtl/delta_event_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delta_event_packer                                         |
// | Description : Bit-packs {delta, codeword} events MSB-first into a        |
// |               continuous stream and emits fixed WORD_W-bit words over a  |
// |               valid/ready handshake. bin_end flushes the partial word    |
// |               zero-padded with out_last=1.                               |
// |               Optional macro BIN_MARKER_EN: append an all-ones CH_BIT    |
// |               marker to every bin before padding.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module delta_event_packer #(
  parameter int CH_BIT = 7,
  parameter int MAX_CW = 8,
  parameter int LEN_W  = 4,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [CH_BIT-1:0] ev_delta,
  input  logic [MAX_CW-1:0] ev_cw,
  input  logic [LEN_W-1:0]  ev_len,
  input  logic              bin_end,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              flush_done
);

  localparam int ACC_W  = WORD_W + CH_BIT + MAX_CW - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int FLD_W  = CH_BIT + MAX_CW;

  localparam logic [FILL_W-1:0] c_word_fill = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] c_ch_fill   = FILL_W'(CH_BIT);
  localparam logic [LEN_W-1:0]  c_max_len   = LEN_W'(MAX_CW);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [ACC_W-1:0]    r_acc;
  logic [FILL_W-1:0]   r_fill;
  logic                r_flush_pend;
  logic [WORD_W-1:0]   r_out_word;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_flush_done;
  logic                w_done_nx;

  logic                w_pop;
  logic                w_accept;
  logic                w_append;
  logic                w_mark_push;
  logic                w_mark_wait;
  logic [LEN_W-1:0]    w_len_c;
  logic [MAX_CW-1:0]   w_cw_mask;
  logic [MAX_CW-1:0]   w_cw_top;
  logic [FLD_W-1:0]    w_app_field;
  logic [FILL_W-1:0]   w_app_bits;
  logic [ACC_W-1:0]    w_acc_sh;
  logic [FILL_W-1:0]   w_fill_sh;
  logic [ACC_W-1:0]    w_acc_nx;
  logic [FILL_W-1:0]   w_fill_nx;

  assign ev_ready   = (r_state == ST_RUN) && (r_fill < c_word_fill);
  assign w_pop      = r_out_valid & out_ready;
  assign w_accept   = ev_valid & ev_ready;
  assign out_word   = r_out_word;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign flush_done = r_flush_done;

`ifdef BIN_MARKER_EN
  logic r_mark_pend;
  // The marker is appended once the accumulator has room, i.e. after any full words drain.
  assign w_mark_push = r_mark_pend && (r_state == ST_FLUSH) && (r_fill < c_word_fill);
  assign w_mark_wait = r_mark_pend;

  // Arm the marker on every RUN->FLUSH transition, clear it once appended.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_mark_pend <= 1'b0;
    end else if ((r_state == ST_RUN) && (w_state_nx == ST_FLUSH)) begin
      r_mark_pend <= 1'b1;
    end else if (w_mark_push) begin
      r_mark_pend <= 1'b0;
    end
  end
`else
  assign w_mark_push = 1'b0;
  assign w_mark_wait = 1'b0;
`endif

  // Build the field to append (event or marker) and the accumulator next state; pop shifts first.
  always_comb begin
    w_len_c     = (ev_len > c_max_len) ? c_max_len : ev_len;
    w_cw_mask   = ~({MAX_CW{1'b1}} << w_len_c);
    w_cw_top    = (ev_cw & w_cw_mask) << (c_max_len - w_len_c);
    w_append    = w_accept | w_mark_push;
    w_app_field = w_accept ? {ev_delta, w_cw_top} : {{CH_BIT{1'b1}}, {MAX_CW{1'b0}}};
    w_app_bits  = w_accept ? (c_ch_fill + FILL_W'(w_len_c)) : c_ch_fill;
    w_acc_sh    = r_acc;
    w_fill_sh   = r_fill;
    if (w_pop) begin
      w_acc_sh  = r_acc << WORD_W;
      w_fill_sh = (r_fill >= c_word_fill) ? (r_fill - c_word_fill) : '0;
    end
    w_acc_nx  = w_acc_sh;
    w_fill_nx = w_fill_sh;
    if (w_append) begin
      w_acc_nx  = w_acc_sh | ({w_app_field, {(ACC_W-FLD_W){1'b0}}} >> w_fill_sh);
      w_fill_nx = w_fill_sh + w_app_bits;
    end
  end

  // Flush sequencing: RUN -> FLUSH -> DRAIN -> RUN, with flush_done on completion.
  always_comb begin
    w_state_nx = r_state;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bin_end || r_flush_pend) w_state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((r_fill < c_word_fill) && !w_mark_wait) w_state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_fill == '0) || w_pop) begin
          w_state_nx = ST_RUN;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_state <= ST_RUN;
    else      r_state <= w_state_nx;
  end

  // Accumulator, pending-flush latch and flush_done pulse.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_acc        <= '0;
      r_fill       <= '0;
      r_flush_pend <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_acc        <= w_acc_nx;
      r_fill       <= w_fill_nx;
      r_flush_done <= w_done_nx;
      if (r_state == ST_RUN)  r_flush_pend <= 1'b0;
      else if (bin_end)       r_flush_pend <= 1'b1;
    end
  end

  // Output word register: loads a full word, or the padded remainder in DRAIN; holds until popped.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (!r_out_valid) begin
      if (r_fill >= c_word_fill) begin
        r_out_valid <= 1'b1;
        r_out_word  <= r_acc[ACC_W-1 -: WORD_W];
        r_out_last  <= 1'b0;
      end else if ((r_state == ST_DRAIN) && (r_fill != '0)) begin
        r_out_valid <= 1'b1;
        r_out_word  <= r_acc[ACC_W-1 -: WORD_W];
        r_out_last  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_delta_event_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_delta_event_packer                                      |
// | Description : Self-checking bench for delta_event_packer; directed steps |
// |               plus random events against a bit-queue reference model.    |
// |               Expectations follow BIN_MARKER_EN when it is defined.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_delta_event_packer;

  localparam int CH_BIT = 7;
  localparam int MAX_CW = 8;
  localparam int LEN_W  = 4;
  localparam int WORD_W = 16;

  logic              clk = 1'b0;
  logic              RST;
  logic              ev_valid;
  logic              ev_ready;
  logic [CH_BIT-1:0] ev_delta;
  logic [MAX_CW-1:0] ev_cw;
  logic [LEN_W-1:0]  ev_len;
  logic              bin_end;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              flush_done;

  always #5 clk = ~clk;

  delta_event_packer #(
    .CH_BIT(CH_BIT), .MAX_CW(MAX_CW), .LEN_W(LEN_W), .WORD_W(WORD_W)
  ) dut (
    .clk(clk), .RST(RST),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_delta(ev_delta), .ev_cw(ev_cw), .ev_len(ev_len),
    .bin_end(bin_end),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .flush_done(flush_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain queue of stream bits, cut into 16-bit words.
  typedef struct {
    logic [WORD_W-1:0] w;
    logic              last;
    int                nbits;
  } exp_t;

  exp_t              exp_q[$];
  bit                bits_q[$];
  int                m_fill = 0;
  bit                m_busy = 1'b0;
  bit                m_pend = 1'b0;
  int                m_flushes = 0;
  int                fd_seen = 0;
  int                pop_count = 0;
  logic [WORD_W-1:0] last_word = '0;
  logic              last_flag = 1'b0;
  bit                rnd_ready = 1'b0;

  function automatic void pack_full();
    while (bits_q.size() >= WORD_W) begin
      exp_t e;
      e.w = '0;
      for (int i = 0; i < WORD_W; i++) e.w[WORD_W-1-i] = bits_q.pop_front();
      e.last  = 1'b0;
      e.nbits = WORD_W;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void m_accept(input logic [CH_BIT-1:0] d, input logic [MAX_CW-1:0] c,
                                   input logic [LEN_W-1:0] l);
    int n;
    n = (int'(l) > MAX_CW) ? MAX_CW : int'(l);
    for (int i = CH_BIT-1; i >= 0; i--) bits_q.push_back(d[i]);
    for (int i = n-1; i >= 0; i--) bits_q.push_back(c[i]);
    m_fill += CH_BIT + n;
    pack_full();
  endfunction

  function automatic void m_flush();
    exp_t e;
    int   n;
`ifdef BIN_MARKER_EN
    for (int i = 0; i < CH_BIT; i++) bits_q.push_back(1'b1);
    m_fill += CH_BIT;
`endif
    pack_full();
    n = bits_q.size();
    if (n > 0) begin
      e.w = '0;
      for (int i = 0; i < n; i++) e.w[WORD_W-1-i] = bits_q.pop_front();
      e.last  = 1'b1;
      e.nbits = n;
      exp_q.push_back(e);
    end
    m_flushes++;
  endfunction

  // Monitor: follows the handshakes on the falling edge and checks every popped word.
  always @(negedge clk) begin
    exp_t e;
    bit   skip;
    skip = 1'b0;
    if (!RST) begin
      bits_q.delete();
      exp_q.delete();
      m_fill = 0;
      m_busy = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (flush_done) begin
        fd_seen++;
        if (m_pend) begin
          m_pend = 1'b0;
          skip   = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end
      if (!skip) check("ev_ready", 32'(ev_ready), 32'(!m_busy && (m_fill < WORD_W)));
      if (ev_valid && ev_ready) m_accept(ev_delta, ev_cw, ev_len);
      if (bin_end) begin
        if (!m_busy) begin
          m_busy = 1'b1;
          m_flush();
        end else if (!m_pend) begin
          m_pend = 1'b1;
          m_flush();
        end
      end
      if (out_valid && out_ready) begin
        pop_count++;
        last_word = out_word;
        last_flag = out_last;
        if (exp_q.size() == 0) begin
          check("pop_word_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(out_word), 32'(e.w));
          check("last", 32'(out_last), 32'(e.last));
          m_fill -= e.nbits;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [CH_BIT-1:0] d, input logic [MAX_CW-1:0] c,
                      input logic [LEN_W-1:0] l);
    bit got;
    got      = 1'b0;
    ev_valid = 1'b1;
    ev_delta = d;
    ev_cw    = c;
    ev_len   = l;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      got = ev_ready;
      tick();
      if (got) break;
    end
    ev_valid = 1'b0;
    check("ev_accept_wait", 32'(got), 32'd1);
  endtask

  task automatic bin_pulse();
    bin_end = 1'b1;
    tick();
    bin_end = 1'b0;
  endtask

  task automatic wait_fd(input int want);
    for (int k = 0; k < 1000; k++) begin
      if (fd_seen >= want) break;
      tick();
    end
    check("flush_done_wait", 32'(fd_seen >= want), 32'd1);
  endtask

  int                p0;
  int                f0;
  logic [WORD_W-1:0] w0;

  initial begin
    RST       = 1'b0;
    ev_valid  = 1'b0;
    ev_delta  = '0;
    ev_cw     = '0;
    ev_len    = '0;
    bin_end   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ev_ready", 32'(ev_ready), 32'd1);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    RST = 1'b1;
    repeat (3) tick();
    check("hold_out_valid", 32'(out_valid), 32'd0);
    check("hold_ev_ready", 32'(ev_ready), 32'd1);

    // Basic pack: 18 bits -> one word 0740, residual "11".
    p0 = pop_count;
    send(7'd3, 8'b101, 4'd3);
    send(7'd1, 8'b1, 4'd1);
    repeat (4) tick();
    check("pack_pops", 32'(pop_count - p0), 32'd1);
    check("pack_word", 32'(last_word), 32'h0740);
    check("pack_last", 32'(last_flag), 32'd0);

    // Flush of the residual.
    f0 = fd_seen;
    bin_pulse();
    wait_fd(f0 + 1);
`ifdef BIN_MARKER_EN
    check("flush_word", 32'(last_word), 32'hFF80);
`else
    check("flush_word", 32'(last_word), 32'hC000);
`endif
    check("flush_last", 32'(last_flag), 32'd1);
    check("flush_pops", 32'(pop_count - p0), 32'd2);

    // Backpressure: word held stable, no events accepted.
    out_ready = 1'b0;
    send(7'd10, 8'hAB, 4'd8);
    send(7'd20, 8'h0F, 4'd4);
    repeat (2) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_word", 32'(out_word), 32'h1556);
    w0 = out_word;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_stable", 32'(out_word), 32'(w0));
      check("bp_ready_low", 32'(ev_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_ready_after_pop", 32'(ev_ready), 32'd1);
    out_ready = 1'b1;
    f0 = fd_seen;
    bin_pulse();
    wait_fd(f0 + 1);

    // Length edges: zero length and clamped length.
    p0 = pop_count;
    send(7'd5, 8'h5A, 4'd0);
    send(7'd5, 8'hFF, 4'd12);
    repeat (4) tick();
    check("len_word", 32'(last_word), 32'h0A17);
    f0 = fd_seen;
    bin_pulse();
    wait_fd(f0 + 1);
`ifdef BIN_MARKER_EN
    check("len_flush_word", 32'(last_word), 32'hFFF8);
`else
    check("len_flush_word", 32'(last_word), 32'hFC00);
`endif
    check("len_pops", 32'(pop_count - p0), 32'd2);

    // Empty bin.
    p0 = pop_count;
    f0 = fd_seen;
    bin_pulse();
    wait_fd(f0 + 1);
    repeat (3) tick();
`ifdef BIN_MARKER_EN
    check("empty_pops", 32'(pop_count - p0), 32'd1);
    check("empty_word", 32'(last_word), 32'hFE00);
`else
    check("empty_pops", 32'(pop_count - p0), 32'd0);
`endif

    // Back-to-back bin_end: one pending flush kept, the third pulse dropped.
    f0 = fd_seen;
    bin_pulse();
    bin_pulse();
    bin_pulse();
    wait_fd(f0 + 2);
    repeat (20) tick();
    check("pend_flush_count", 32'(fd_seen - f0), 32'd2);

    // Reset in the middle of a bin discards the partial bits.
    send(7'd1, 8'b11, 4'd2);
    tick();
    RST = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();
    RST = 1'b1;
    tick();
    p0 = pop_count;
    send(7'd3, 8'b101, 4'd3);
    send(7'd1, 8'b1, 4'd1);
    repeat (4) tick();
    check("midrst_word", 32'(last_word), 32'h0740);
    f0 = fd_seen;
    bin_pulse();
    wait_fd(f0 + 1);

    // Random events with random sink stalls and occasional bins.
    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send(7'($urandom_range(1, 96)), 8'($urandom), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 19) == 0) begin
        f0 = fd_seen;
        bin_pulse();
        wait_fd(f0 + 1);
      end else if ($urandom_range(0, 29) == 0) begin
        f0       = fd_seen;
        ev_valid = 1'b1;
        ev_delta = 7'($urandom_range(1, 96));
        ev_cw    = 8'($urandom);
        ev_len   = 4'($urandom_range(0, 8));
        bin_end  = 1'b1;
        tick();
        ev_valid = 1'b0;
        bin_end  = 1'b0;
        wait_fd(f0 + 1);
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    f0 = fd_seen;
    bin_pulse();
    wait_fd(f0 + 1);
    repeat (5) tick();
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_flush_count", 32'(fd_seen), 32'(m_flushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
